ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU and owns all M-extension operations. EX hands it operands and `funct3` with a start pulse. The block holds the pipeline via `stall_o` while it runs a 32-step shift-add or restoring-divide schedule. It then presents a one-cycle `done_o` with the 32-bit result for writeback.

---
 rtl/ex_muldiv.sv | 218 +++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Latency: 34 cycles from accepted start to done_o (shift-add / restoring divide),
//          1 cycle for divide-by-zero and signed-overflow fast paths.
// Backpressure: stall_o holds EX and earlier stages from the accepting cycle through FIX;
//               start_i is ignored while busy, kill_i aborts to IDLE in any state.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start_i, kill_i   request (sampled in IDLE only) and flush (wins over start)
//   funct3_i          M-extension opcode: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   op_a_i, op_b_i    rs1 / rs2 values
//   busy_o            sequencer is not idle
//   stall_o           combinational pipeline hold request
//   done_o, result_o  one-cycle result strobe and registered result
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_CNT = 6'(XLEN - 1);

    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;          // product / quotient sign
    logic              neg_rem_q, neg_rem_d;  // remainder follows the dividend
    logic [XLEN-1:0]   opnd_q, opnd_d;        // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0] acc_q, acc_d;          // {hi, lo} for mul, {rem, quot} for div
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    // ------------------------------------------------------------------
    // Start-time operand conditioning
    // ------------------------------------------------------------------
    logic            is_div;
    logic            a_sgn, b_sgn;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        is_div = funct3_i[2];
        // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2.
        // MUL needs no sign handling: the low half is signedness-agnostic.
        a_sgn  = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                 (funct3_i == 3'b100) || (funct3_i == 3'b110);
        b_sgn  = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                 (funct3_i == 3'b110);
        a_neg  = a_sgn & op_a_i[XLEN-1];
        b_neg  = b_sgn & op_b_i[XLEN-1];
        // INT_MIN negates to itself, which is the correct unsigned magnitude.
        a_mag  = a_neg ? -op_a_i : op_a_i;
        b_mag  = b_neg ? -op_b_i : op_b_i;

        div_by_zero = is_div && (op_b_i == '0);
        div_ovf     = is_div && !funct3_i[0] &&
                      (op_a_i == INT_MIN) && (op_b_i == ALL_ONES);

        // funct3[1] distinguishes REM* from DIV*.
        if (div_by_zero) begin
            fast_res = funct3_i[1] ? op_a_i : ALL_ONES;
        end else begin
            fast_res = funct3_i[1] ? '0 : INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply and restoring divide
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        // Carry out of the upper-half add shifts down into bit 2*XLEN-1.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // rem < divisor always holds, so the shifted remainder fits in
        // XLEN+1 bits and the borrow lands in the top bit of the difference.
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic [XLEN-1:0]   fix_sel;

    always_comb begin
        prod_fix = neg_q     ? -acc_q                  : acc_q;
        quot_fix = neg_q     ? -acc_q[XLEN-1:0]        : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN]   : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:                 fix_sel = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_sel = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_sel = quot_fix;
            default:                fix_sel = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        result_d  = result_q;
        done_d    = 1'b0;

        if (kill_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        f3_d      = funct3_i;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = '0;
                        if (div_by_zero || div_ovf) begin
                            result_d = fast_res;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            // Divide starts with the dividend in the quotient
                            // half; multiply starts with the multiplier in lo.
                            opnd_d  = is_div ? b_mag : a_mag;
                            acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = f3_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = fix_sel;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    // stall drops in DONE so EX advances while writeback captures result_o.
    assign stall_o  = ((state_q == S_IDLE) && start_i && !kill_i) ||
                      (state_q == S_CALC) || (state_q == S_FIX);
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] op_a_i = 32'd0;
    logic [31:0] op_b_i = 32'd0;
    logic        busy_o, stall_o, done_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .kill_i   (kill_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an M-extension op, computed with wide arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 32'd0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end end
            3'd5: begin if (b == 0) r = 32'hFFFF_FFFF; else begin p = ua / ub; r = p[31:0]; end end
            3'd6: begin if (b == 0) r = a;             else begin p = sa % sb; r = p[31:0]; end end
            default: begin if (b == 0) r = a;          else begin p = ua % ub; r = p[31:0]; end end
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Transaction-level model: cycles remaining until idle, result visible at done.
    int          m_left = 0;
    logic [31:0] m_res  = 32'd0;
    logic [31:0] m_pend = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_res  <= 32'd0;
        end else if (kill_i) begin
            m_left <= 0;
        end else if (m_left == 0) begin
            if (start_i) begin
                m_pend <= ref_res(funct3_i, op_a_i, op_b_i);
                if (is_fast(funct3_i, op_a_i, op_b_i)) begin
                    m_left <= 1;
                    m_res  <= ref_res(funct3_i, op_a_i, op_b_i);
                end else begin
                    m_left <= 34;
                end
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_res <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check("cmp busy",   32'(busy_o),  32'(m_left != 0));
            check("cmp done",   32'(done_o),  32'(m_left == 1));
            check("cmp stall",  32'(stall_o), 32'((m_left == 0 && start_i && !kill_i) || m_left > 1));
            check("cmp result", result_o,     m_res);
        end
    end

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        int stalls;
        bit seen;
        @(posedge clk); #1;
        funct3_i = f; op_a_i = a; op_b_i = b; start_i = 1'b1;
        #1 stalls = stall_o ? 1 : 0;
        @(posedge clk); #1;
        start_i  = 1'b0;
        op_a_i   = $urandom;
        op_b_i   = $urandom;
        funct3_i = 3'($urandom_range(7, 0));
        n = 1;
        seen = 1'b0;
        while (n <= 60 && !seen) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (done_o) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
        check({name, " latency"},   32'(n),      32'(exp_lat));
        check({name, " result"},    result_o,    exp);
        check({name, " stalls"},    32'(stalls), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;
        check("reset busy",   32'(busy_o),  32'd0);
        check("reset done",   32'(done_o),  32'd0);
        check("reset stall",  32'(stall_o), 32'd0);
        check("reset result", result_o,     32'd0);
        #10 rst = 1'b0;
        cmp_en = 1'b1;

        run_op("MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("MULHU max*max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("MULHSU -1*2",     3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("MULH -2*3",       3'd1, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 34);
        run_op("MULH min*min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        run_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        run_op("REM -7%2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("DIVU 100/7",      3'd5, 32'd100,        32'd7,         32'd14,        34);
        run_op("REMU 100%7",      3'd7, 32'd100,        32'd7,         32'd2,         34);
        run_op("DIV 7/-2",        3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("REM 7%-2",        3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         34);
        run_op("DIVU max/1",      3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34);
        run_op("DIV 5/0",         3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("REM 5%0",         3'd6, 32'd5,          32'd0,         32'd5,         1);
        run_op("REMU x%0",        3'd7, 32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 1);
        run_op("DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Kill in the 10th CALC cycle.
        @(posedge clk); #1;
        funct3_i = 3'd5; op_a_i = 32'd100; op_b_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        check("kill busy next", 32'(busy_o),  32'd0);
        check("kill stall",     32'(stall_o), 32'd0);
        check("kill result",    result_o,     32'd0);
        n = 0;
        repeat (40) begin @(negedge clk); if (done_o) n++; end
        check("kill no done", 32'(n), 32'd0);
        run_op("DIVU after kill", 3'd5, 32'd100, 32'd7, 32'd14, 34);

        // Kill and start together in IDLE.
        @(posedge clk); #1;
        funct3_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd3; start_i = 1'b1; kill_i = 1'b1;
        #1 check("kill+start stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        start_i = 1'b0; kill_i = 1'b0;
        check("kill+start busy", 32'(busy_o), 32'd0);
        n = 0;
        repeat (5) begin @(negedge clk); if (done_o) n++; end
        check("kill+start no done", 32'(n), 32'd0);

        // Asynchronous reset mid-CALC.
        @(posedge clk); #1;
        funct3_i = 3'd0; op_a_i = 32'd7; op_b_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst busy",   32'(busy_o),  32'd0);
        check("arst done",   32'(done_o),  32'd0);
        check("arst stall",  32'(stall_o), 32'd0);
        check("arst result", result_o,     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        repeat (40) begin @(negedge clk); if (done_o) n++; end
        check("arst no done", 32'(n), 32'd0);
        run_op("MUL after arst", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
